// File: rtl/regfile_loader_if.sv
// Source-stream and register-file port bundle for regfile_loader.
// master = loader side, slave = stream source / register file side.
interface regfile_loader_if #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     s_valid;
  logic [DATA_WIDTH-1:0]    s_data;
  logic                     s_ready;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [ADDRESS_WIDTH-1:0] rb_addr;
  logic [DATA_WIDTH-1:0]    rb_data;

  modport master (
    input  s_valid, s_data, rb_data,
    output s_ready, wr_en, wr_addr, wr_data, rb_addr
  );

  modport slave (
    output s_valid, s_data, rb_data,
    input  s_ready, wr_en, wr_addr, wr_data, rb_addr
  );
endinterface

// File: rtl/regfile_loader.sv
// Streams a contiguous window of words into the register file write port.
// Optional readback check of every write: define REGFILE_LOADER_VERIFY_EN.
module regfile_loader #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     verify_err,
  regfile_loader_if.master         bus
);

  localparam int unsigned CW       = ADDRESS_WIDTH + 1;
  localparam int unsigned NUM_REGS = 1 << ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef REGFILE_LOADER_VERIFY_EN
    VERIFY,
`endif
    DONE
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] ptr;
  logic [CW-1:0]            rem;
  logic [CW-1:0]            load_cnt_c;
  logic                     handshake_c;
  logic                     wr_en_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;

  // Clamp so a single load never writes the same register twice.
  assign load_cnt_c = (count > CW'(NUM_REGS)) ? CW'(NUM_REGS) : count;

`ifdef REGFILE_LOADER_VERIFY_EN
  logic                     verify_err_q;
  logic [ADDRESS_WIDTH-1:0] rb_addr_q;

  // Hold off the source while a write is still committing.
  assign bus.s_ready = (state == LOAD) && !wr_en_q;
  assign bus.rb_addr = rb_addr_q;
  assign verify_err  = verify_err_q;
`else
  logic unused_rb_data;

  assign bus.s_ready    = (state == LOAD);
  assign bus.rb_addr    = '0;
  assign verify_err     = 1'b0;
  assign unused_rb_data = ^bus.rb_data;
`endif

  assign handshake_c = bus.s_valid && bus.s_ready;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      rem       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REGFILE_LOADER_VERIFY_EN
      verify_err_q <= 1'b0;
      rb_addr_q    <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr  <= base_addr;
            rem  <= load_cnt_c;
            busy <= 1'b1;
`ifdef REGFILE_LOADER_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
            if (load_cnt_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
`ifdef REGFILE_LOADER_VERIFY_EN
          if (wr_en_q) begin
            state     <= VERIFY;
            rb_addr_q <= wr_addr_q;
          end else
`endif
          if (handshake_c) begin
            wr_addr_q <= ptr;
            wr_data_q <= bus.s_data;
            wr_en_q   <= (ptr != '0);
            ptr       <= ptr + ADDRESS_WIDTH'(1);
            rem       <= rem - CW'(1);
            if (rem == CW'(1)) begin
`ifdef REGFILE_LOADER_VERIFY_EN
              // A non-x0 final word still has to pass through VERIFY.
              if (ptr == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end
`else
              state <= DONE;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef REGFILE_LOADER_VERIFY_EN
        VERIFY: begin
          if (bus.rb_data != wr_data_q) verify_err_q <= 1'b1;
          if (rem == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_loader.md
Name: regfile_loader

Overview:
- Streaming initiator that fills the register file through its single write port (write enable / destination address / write data).
- Bulk-loads a contiguous register window at run time, e.g. test vectors or a context restore, without relying on the power-up memory-file preload.
- Sits beside the CPU writeback path; `busy` tells the integrator to hold off CPU writes while a load is in progress.

Parameters:
- ADDRESS_WIDTH, 5, register address width (32 registers).
- DATA_WIDTH, 32, register word width.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load; sampled only in IDLE.
- base_addr  input  ADDRESS_WIDTH  first destination register.
- count  input  ADDRESS_WIDTH+1  number of words to load (0..63).
- s_valid  input  1  source word available.
- s_data  input  DATA_WIDTH  source word.
- s_ready  output  1  loader accepts s_data this cycle.
- wr_en  output  1  register-file write enable.
- wr_addr  output  ADDRESS_WIDTH  register-file destination address.
- wr_data  output  DATA_WIDTH  register-file write data.
- rb_addr  output  ADDRESS_WIDTH  register-file read address (verify only).
- rb_data  input  DATA_WIDTH  register-file combinational read data (verify only).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- verify_err  output  1  sticky readback mismatch (verify only).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; internal pointer and remaining count = 0.
  - s_ready, wr_en, done, busy, verify_err = 0; wr_addr, wr_data, rb_addr = 0.
  - Reset mid-load abandons the load immediately; no further wr_en is issued.
- States: IDLE, LOAD, VERIFY (only with the optional feature), DONE.
- IDLE:
  - s_ready=0.
  - When start=1: latch ptr=base_addr and rem=min(count,32).
  - rem==0 -> go to DONE; otherwise go to LOAD.
  - start is ignored in every state other than IDLE.
- LOAD:
  - s_ready=1 combinationally from state.
  - A handshake is s_valid && s_ready at a rising edge N.
  - At edge N the loader registers wr_addr=ptr and wr_data=s_data.
  - wr_en is high during cycle N..N+1 exactly when ptr!=0; the register file commits at edge N+1.
  - A word for ptr==0 is consumed, but wr_en stays 0 (x0 is never written).
  - After each handshake: ptr increments modulo 32 (31 -> 0); rem decrements.
  - On the handshake that makes rem reach 0, go to DONE.
- Without verify, sustained throughput is one word per cycle, and wr_en is high only in cycles following a handshake.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - The final word's wr_en and done are asserted in the same cycle.
- busy=1 in LOAD, VERIFY and DONE.
- count>32 clamps to 32, so no register is written twice in one load.

Optional Feature:
- Macro: REGFILE_LOADER_VERIFY_EN.
- Defined:
  - After a handshake for ptr!=0, the state goes LOAD -> VERIFY for one cycle; s_ready=0 during VERIFY and during the wr_en cycle.
  - In VERIFY, rb_addr=held wr_addr, and rb_data is compared with the held wr_data.
  - A mismatch sets verify_err=1; it stays set until the next accepted start or reset.
  - x0 words skip VERIFY.
  - Peak throughput becomes one word per 3 cycles.
- Undefined:
  - No VERIFY state; rb_addr tied 0; verify_err tied 0; rb_data unused.

Test Plan:
- Basic load: start with base_addr=3, count=4; words 0x11,0x22,0x33,0x44 with s_valid held high -> wr_en for 4 consecutive cycles at addresses 3,4,5,6; done pulses with the write to address 6; register file then reads 0x11..0x44; busy back to 0 the cycle after done.
- Wrap and x0 skip: base_addr=30, count=4, words A,B,C,D -> writes r30=A and r31=B; C consumed with no wr_en; r1=D; r0 unchanged at 0.
- Zero/oversize count:
  - count=0 -> done the cycle after start, no s_ready, no wr_en.
  - count=40 -> exactly 32 handshakes, then done.
- Backpressure: s_valid toggles 1,0,0,1,0,1 -> wr_en only in cycles following a handshake; addresses stay contiguous; start pulses issued mid-load are ignored.
- Reset mid-load: rst_n low after 2 of 5 words -> outputs 0 asynchronously; only 2 registers written; a new start then loads normally.
- Verify (macro defined):
  - Clean load of 3 words -> verify_err stays 0.
  - Bench forces rb_data=0xDEAD on the second word -> verify_err=1 through done and held until the next start.
